stw_test_sequencer: RTL and testbench

Autonomous sequencer for the stop-the-world (STW) self-test port of the weight-proxy systolic array. It sits directly upstream of the array's STW inputs and downstream of its STW result outputs. It waits for the matmul FSM to report the array idle, then applies a fixed set of test vectors. After each vector it collects the per-PE pass/fail matrix and ORs the results into a sticky fault map that the repair/proxy logic consumes.

---
 rtl/stw_test_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_stw_test_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/stw_test_sequencer.sv
// stw_test_sequencer: waits for the systolic array to go idle, drives a fixed
// set of four STW test vectors through the array's self-test port, and ORs
// every per-PE failure seen into a sticky fault map with a popcount.
module stw_test_sequencer #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req,
  input  logic                               clear_map,
  input  logic                               array_idle,
  output logic                               STW_test_load_en,
  output logic [WORD_SIZE-1:0]               STW_mult_op1,
  output logic [WORD_SIZE-1:0]               STW_mult_op2,
  output logic [WORD_SIZE-1:0]               STW_add_op,
  output logic [WORD_SIZE-1:0]               STW_expected,
  output logic                               STW_start,
  input  logic                               STW_complete,
  input  logic [ROWS*COLS-1:0]               STW_result_mat,
  output logic                               busy,
  output logic                               done,
  output logic [ROWS*COLS-1:0]               fault_map,
  output logic [$clog2(ROWS*COLS+1)-1:0]     fault_count,
  output logic                               new_fault,
  output logic                               timeout_err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_IDLE, S_LOAD, S_START, S_WAIT, S_ACCUM, S_FINISH, S_ABORT
  } state_t;

  state_t                 state_q;
  logic [1:0]             v_q;
  logic [TW-1:0]          cnt_q;
  logic [N-1:0]           acc_q;
  logic [N-1:0]           fault_map_q;
  logic [CW-1:0]          fault_count_q;
  logic                   load_en_q, start_q, busy_q, done_q, new_fault_q, terr_q;
  logic [WORD_SIZE-1:0]   op1_q, op2_q, add_q, exp_q;

  logic [1:0]             vidx_d;
  logic [4*WORD_SIZE-1:0] vec_d;
  logic [N-1:0]           acc_d;
  logic [N-1:0]           map_d;

  // Fixed test vector table; results are truncated to the operand width.
  function automatic logic [4*WORD_SIZE-1:0] vec_word(input logic [1:0] v);
    logic [WORD_SIZE-1:0] o1, o2, ad, ex;
    case (v)
      2'd0:    begin o1 = WORD_SIZE'(4);      o2 = WORD_SIZE'(3);   ad = '0;             ex = WORD_SIZE'(12);      end
      2'd1:    begin o1 = WORD_SIZE'(16'hFFFF); o2 = WORD_SIZE'(1); ad = '0;             ex = WORD_SIZE'(16'hFFFF); end
      2'd2:    begin o1 = '0;                 o2 = WORD_SIZE'(5);   ad = WORD_SIZE'(7);  ex = WORD_SIZE'(7);       end
      default: begin o1 = WORD_SIZE'(255);    o2 = WORD_SIZE'(255); ad = WORD_SIZE'(1);  ex = WORD_SIZE'(65026);   end
    endcase
    return {o1, o2, ad, ex};
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  // Next vector to present and the fault accumulation for the current sample.
  always_comb begin
    vidx_d = (state_q == S_ACCUM) ? v_q + 2'd1 : v_q;
    vec_d  = vec_word(vidx_d);
    acc_d  = acc_q | ~STW_result_mat;
    map_d  = fault_map_q | acc_d;
  end

  // Campaign FSM; every output is a register set on entry to the state it belongs to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      v_q           <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      fault_map_q   <= '0;
      fault_count_q <= '0;
      load_en_q     <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      new_fault_q   <= 1'b0;
      terr_q        <= 1'b0;
      op1_q         <= '0;
      op2_q         <= '0;
      add_q         <= '0;
      exp_q         <= '0;
    end else begin
      load_en_q   <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      new_fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (clear_map) begin
            fault_map_q   <= '0;
            fault_count_q <= '0;
          end
          if (req) begin
            state_q <= S_WAIT_IDLE;
            v_q     <= '0;
            acc_q   <= '0;
            terr_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (array_idle) begin
            state_q   <= S_LOAD;
            load_en_q <= 1'b1;
            {op1_q, op2_q, add_q, exp_q} <= vec_d;
          end
        end
        S_LOAD: begin
          state_q <= S_START;
          start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (STW_complete) begin
            state_q <= S_ACCUM;
          end else if (cnt_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_ABORT;
            terr_q  <= 1'b1;
            done_q  <= 1'b1;
            {op1_q, op2_q, add_q, exp_q} <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          if (v_q == 2'd3) begin
            state_q       <= S_FINISH;
            fault_map_q   <= map_d;
            fault_count_q <= popcount(map_d);
            done_q        <= 1'b1;
            new_fault_q   <= |(acc_d & ~fault_map_q);
            {op1_q, op2_q, add_q, exp_q} <= '0;
          end else begin
            state_q   <= S_LOAD;
            v_q       <= vidx_d;
            load_en_q <= 1'b1;
            {op1_q, op2_q, add_q, exp_q} <= vec_d;
          end
        end
        S_FINISH, S_ABORT: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign STW_test_load_en = load_en_q;
  assign STW_start        = start_q;
  assign STW_mult_op1     = op1_q;
  assign STW_mult_op2     = op2_q;
  assign STW_add_op       = add_q;
  assign STW_expected     = exp_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign fault_map        = fault_map_q;
  assign fault_count      = fault_count_q;
  assign new_fault        = new_fault_q;
  assign timeout_err      = terr_q;

endmodule

// File: tb/tb_stw_test_sequencer.sv
// Scoreboard bench for stw_test_sequencer: a reactive array model answers the
// STW port, stimulus pushes expected load/done events, a monitor checks them.
module tb_stw_test_sequencer;

  logic        clk = 1'b0;
  logic        rst, req, clear_map, array_idle;
  logic        STW_test_load_en, STW_start, STW_complete;
  logic [15:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
  logic [15:0] STW_result_mat;
  logic        busy, done, new_fault, timeout_err;
  logic [15:0] fault_map;
  logic [4:0]  fault_count;

  logic        comp_en, hang_v2;
  logic [15:0] fault_mask;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic        prev_load;

  typedef struct {
    bit          is_done;
    logic [15:0] o1, o2, ad, ex;
    logic [15:0] map;
    logic [4:0]  cnt;
    logic        nf, te;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  logic [15:0] V_O1 [4] = '{16'd4, 16'hFFFF, 16'd0, 16'd255};
  logic [15:0] V_O2 [4] = '{16'd3, 16'd1,    16'd5, 16'd255};
  logic [15:0] V_AD [4] = '{16'd0, 16'd0,    16'd7, 16'd1};
  logic [15:0] V_EX [4] = '{16'd12, 16'hFFFF, 16'd7, 16'd65026};

  stw_test_sequencer #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .req(req), .clear_map(clear_map), .array_idle(array_idle),
    .STW_test_load_en(STW_test_load_en), .STW_mult_op1(STW_mult_op1),
    .STW_mult_op2(STW_mult_op2), .STW_add_op(STW_add_op), .STW_expected(STW_expected),
    .STW_start(STW_start), .STW_complete(STW_complete), .STW_result_mat(STW_result_mat),
    .busy(busy), .done(done), .fault_map(fault_map), .fault_count(fault_count),
    .new_fault(new_fault), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: faulty PEs fail only on the 255*255 vector; v2 can be made to hang.
  always_comb begin
    STW_result_mat = (STW_mult_op1 == 16'd255 && STW_mult_op2 == 16'd255) ? ~fault_mask : 16'hFFFF;
    STW_complete   = comp_en && !(hang_v2 && STW_mult_op1 == 16'd0 && STW_mult_op2 == 16'd5);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: pops one expected event for every load strobe or done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_load <= 1'b0;
    end else begin
      prev_load <= STW_test_load_en;
      if (prev_load) chk("start_after_load", STW_start, 1'b1);
      if (new_fault && !done) chk("new_fault_without_done", new_fault, 1'b0);
      if (STW_test_load_en || done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", {STW_test_load_en, done}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("event_kind", done, e.is_done);
          chk("event_cycle", cyc, e.cyc);
          chk("busy_at_event", busy, 1'b1);
          if (e.is_done) begin
            chk("fault_map", fault_map, e.map);
            chk("fault_count", fault_count, e.cnt);
            chk("new_fault", new_fault, e.nf);
            chk("timeout_err", timeout_err, e.te);
          end else begin
            chk("op_vector", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected},
                {e.o1, e.o2, e.ad, e.ex});
          end
        end
      end
    end
  end

  // Push expected events for one campaign and pulse req; call right after a negedge.
  task automatic issue(input int load_off, input int nvec, input int done_off,
                       input logic [15:0] map, input logic [4:0] cnt,
                       input logic nf, input logic te);
    exp_t e;
    int rc;
    rc = cyc;
    for (int v = 0; v < nvec; v++) begin
      e = '{is_done: 1'b0, o1: V_O1[v], o2: V_O2[v], ad: V_AD[v], ex: V_EX[v],
            map: '0, cnt: '0, nf: 1'b0, te: 1'b0, cyc: rc + load_off + 4 * v};
      sb_q.push_back(e);
    end
    if (done_off > 0) begin
      e = '{is_done: 1'b1, o1: '0, o2: '0, ad: '0, ex: '0,
            map: map, cnt: cnt, nf: nf, te: te, cyc: rc + done_off};
      sb_q.push_back(e);
    end
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("campaign_drained", (n < 100), 1'b1);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; clear_map = 1'b0; array_idle = 1'b1;
    comp_en = 1'b1; hang_v2 = 1'b0; fault_mask = 16'h0000;
    #1;
    chk("reset_outputs", {STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
        STW_start, busy, done, fault_map, fault_count, new_fault, timeout_err}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Clean array.
    issue(2, 4, 18, 16'h0000, 5'd0, 1'b0, 1'b0);
    chk("busy_after_req", busy, 1'b1);
    drain();

    // Faults at bits 1, 6, 11, 12 under v3 only.
    fault_mask = 16'h1842;
    issue(2, 4, 18, 16'h1842, 5'd4, 1'b1, 1'b0);
    drain();

    // Rerun with same faults; clear_map and req while busy are ignored.
    issue(2, 4, 18, 16'h1842, 5'd4, 1'b0, 1'b0);
    clear_map = 1'b1; req = 1'b1;
    @(negedge clk);
    clear_map = 1'b0; req = 1'b0;
    drain();

    // clear_map and req together: map cleared, campaign refinds the faults.
    clear_map = 1'b1;
    issue(2, 4, 18, 16'h1842, 5'd4, 1'b1, 1'b0);
    clear_map = 1'b0;
    drain();

    // clear_map alone.
    clear_map = 1'b1;
    @(negedge clk);
    clear_map = 1'b0;
    chk("clear_map_map", fault_map, 16'h0000);
    chk("clear_map_count", fault_count, 5'd0);

    // array_idle low for 10 cycles after req, then dropped mid-campaign.
    fault_mask = 16'h0000;
    array_idle = 1'b0;
    issue(12, 4, 28, 16'h0000, 5'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    array_idle = 1'b1;
    repeat (4) @(negedge clk);
    array_idle = 1'b0;
    drain();
    array_idle = 1'b1;

    // STW_complete never arrives: abort 32 cycles into v0's WAIT.
    comp_en = 1'b0;
    issue(2, 1, 36, 16'h0000, 5'd0, 1'b0, 1'b1);
    drain();
    repeat (2) @(negedge clk);
    chk("timeout_err_sticky", timeout_err, 1'b1);
    comp_en = 1'b1;
    issue(2, 4, 18, 16'h0000, 5'd0, 1'b0, 1'b0);
    chk("timeout_err_cleared_by_req", timeout_err, 1'b0);
    drain();

    // Reset asserted during v2's WAIT.
    fault_mask = 16'h1842;
    hang_v2 = 1'b1;
    issue(2, 3, 0, 16'h0000, 5'd0, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_reset_outputs", {STW_test_load_en, STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected,
        STW_start, busy, done, fault_map, fault_count, new_fault, timeout_err}, '0);
    chk("mid_reset_events_consumed", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hang_v2 = 1'b0;
    fault_mask = 16'h0000;
    @(negedge clk);
    issue(2, 4, 18, 16'h0000, 5'd0, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
